// File: rtl/instruction_loader_pkg.sv
// Shared types and constants for the instruction loader.
// The CHECK state exists only when LOADER_CHECKSUM_EN is defined.
package loader_pkg;

  localparam int BYTES_PER_WORD    = 4;
  localparam int DEFAULT_ADDR_STEP = 4;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    COLLECT = 3'd1,
    WRITE   = 3'd2,
`ifdef LOADER_CHECKSUM_EN
    CHECK   = 3'd3,
`endif
    FINISH  = 3'd4
  } loader_state_t;

  // Big-endian packing: earlier bytes migrate toward the MSBs.
  function automatic logic [31:0] pack_byte(input logic [31:0] word, input logic [7:0] data);
    return {word[23:0], data};
  endfunction

endpackage

// File: rtl/instruction_loader_if.sv
// Host-side handshake and instruction-memory bus of the loader.
// checksum_error is present only when LOADER_CHECKSUM_EN is defined.
interface instruction_loader_if;

  logic        start;
  logic [7:0]  word_count;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        imem_write_en;
  logic [31:0] imem_address;
  logic [31:0] imem_write_data;
  logic        cpu_hold;
  logic        busy;
  logic        done;
`ifdef LOADER_CHECKSUM_EN
  logic        checksum_error;

  modport master (
    output start, word_count, byte_valid, byte_data,
    input  byte_ready, imem_write_en, imem_address, imem_write_data,
    input  cpu_hold, busy, done, checksum_error
  );

  modport slave (
    input  start, word_count, byte_valid, byte_data,
    output byte_ready, imem_write_en, imem_address, imem_write_data,
    output cpu_hold, busy, done, checksum_error
  );
`else
  modport master (
    output start, word_count, byte_valid, byte_data,
    input  byte_ready, imem_write_en, imem_address, imem_write_data,
    input  cpu_hold, busy, done
  );

  modport slave (
    input  start, word_count, byte_valid, byte_data,
    output byte_ready, imem_write_en, imem_address, imem_write_data,
    output cpu_hold, busy, done
  );
`endif

endinterface

// File: rtl/instruction_loader_byte_packer.sv
// 8-to-32 big-endian shift register with a 2-bit byte counter;
// word_full flags the shift that completes the current word.
module byte_packer
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        shift_en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic [1:0]  byte_count,
  output logic        word_full
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word       <= '0;
      byte_count <= '0;
    end else if (clear) begin
      word       <= '0;
      byte_count <= '0;
    end else if (shift_en) begin
      word       <= pack_byte(word, byte_in);
      byte_count <= byte_count + 2'd1;
    end
  end

  assign word_full = shift_en && (byte_count == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/instruction_loader.sv
// Loads a byte stream into instruction memory as 32-bit words while holding the CPU.
// Optional trailing XOR checksum byte is enabled by LOADER_CHECKSUM_EN.
module instruction_loader
  import loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [31:0] ADDR_STEP = 32'(DEFAULT_ADDR_STEP)
)
(
  input logic                 clk,
  input logic                 reset,
  instruction_loader_if.slave bus
);

  loader_state_t state;
  loader_state_t next_state;

  logic [7:0]  words_left;
  logic [31:0] address;
  logic [31:0] packed_word;
  logic [1:0]  byte_count;
  logic        word_full;
  logic        start_ok;
  logic        accept;
  logic        shift_en;

  logic ready;
  logic write_en;
  logic in_session;
  logic done_pulse;

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] checksum_acc;
  logic       checksum_error;
`endif

  assign start_ok = (state == IDLE) && bus.start;
  assign accept   = bus.byte_valid && ready;
  assign shift_en = accept && (state == COLLECT);

  byte_packer packer (
    .clk        (clk),
    .reset      (reset),
    .clear      (start_ok),
    .shift_en   (shift_en),
    .byte_in    (bus.byte_data),
    .word       (packed_word),
    .byte_count (byte_count),
    .word_full  (word_full)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (bus.start) next_state = (bus.word_count != 8'd0) ? COLLECT : FINISH;
      end
      COLLECT: begin
        if (word_full) next_state = WRITE;
      end
      WRITE: begin
`ifdef LOADER_CHECKSUM_EN
        next_state = (words_left == 8'd1) ? CHECK : COLLECT;
`else
        next_state = (words_left == 8'd1) ? FINISH : COLLECT;
`endif
      end
`ifdef LOADER_CHECKSUM_EN
      CHECK: begin
        if (accept) next_state = FINISH;
      end
`endif
      FINISH:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    ready      = 1'b0;
    write_en   = 1'b0;
    in_session = (state != IDLE);
    done_pulse = 1'b0;
    case (state)
      COLLECT: ready      = 1'b1;
      WRITE:   write_en   = 1'b1;
`ifdef LOADER_CHECKSUM_EN
      CHECK:   ready      = 1'b1;
`endif
      FINISH:  done_pulse = 1'b1;
      default: ;
    endcase
  end

  // Address advances on leaving WRITE so it stays stable during the strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      words_left <= '0;
      address    <= BASE_ADDR;
    end else if (start_ok) begin
      words_left <= bus.word_count;
      address    <= BASE_ADDR;
    end else if (state == WRITE) begin
      words_left <= words_left - 8'd1;
      address    <= address + ADDR_STEP;
    end
  end

`ifdef LOADER_CHECKSUM_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      checksum_acc   <= '0;
      checksum_error <= 1'b0;
    end else if (start_ok) begin
      checksum_acc   <= '0;
      checksum_error <= 1'b0;
    end else if (shift_en) begin
      checksum_acc   <= checksum_acc ^ bus.byte_data;
    end else if (accept && (state == CHECK)) begin
      checksum_error <= (bus.byte_data != checksum_acc);
    end
  end

  assign bus.checksum_error = checksum_error;
`endif

  assign bus.byte_ready      = ready;
  assign bus.imem_write_en   = write_en;
  assign bus.imem_address    = address;
  assign bus.imem_write_data = packed_word;
  assign bus.cpu_hold        = in_session;
  assign bus.busy            = in_session;
  assign bus.done            = done_pulse;

endmodule
